fifo_ext: RTL and testbench



---
 rtl/fifo_ext.sv | 143 ++++++++++++++
 tb/tb_fifo_ext.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_ext.sv
// Single-clock FIFO with fill level, optional FWFT read mode, sync clear and sticky error flags.
// Define FIFO_ERR_FLAGS_EN to build the overflow/underflow logic; otherwise both outputs read 0.
module fifo_ext #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_MTY  = 1,
  parameter int unsigned ALMOST_FULL = 1,
  parameter int unsigned FWFT        = 0
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    srst,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH-1:0]   q,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    almost_full,
  output logic                    mty,
  output logic                    almost_mty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_ext: DEPTH must be a power of 2 and >= 2");
  end
  if (ALMOST_MTY >= DEPTH) begin : g_bad_amty
    $error("fifo_ext: ALMOST_MTY must be < DEPTH");
  end
  if (ALMOST_FULL >= DEPTH) begin : g_bad_afull
    $error("fifo_ext: ALMOST_FULL must be < DEPTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_full;
  logic                  r_almost_full;
  logic                  r_mty;
  logic                  r_almost_mty;

  logic [LW-1:0]         w_level;
  logic [LW-1:0]         w_level_next;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [AW-1:0]         w_head_addr;
  logic [DATA_WIDTH-1:0] w_q_next;

  // The wrap bit makes the pointer difference an exact 0..DEPTH count.
  always_comb begin
    w_level      = r_wr_ptr - r_rd_ptr;
    w_rd_acc     = rd & ~r_mty;
    w_wr_acc     = wr & (~r_full | w_rd_acc);
    w_level_next = w_level + LW'(w_wr_acc) - LW'(w_rd_acc);
  end

  if (FWFT != 0) begin : g_fwft
    always_comb begin
      w_head_addr = r_rd_ptr[AW-1:0] + AW'(w_rd_acc);
      w_q_next    = r_q;
      if (w_level_next != '0) begin
        // Nothing left in memory after the read: the head is the word being written now.
        if (w_level == LW'(w_rd_acc)) w_q_next = data;
        else                          w_q_next = r_mem[w_head_addr];
      end
    end
  end else begin : g_std
    always_comb begin
      w_head_addr = r_rd_ptr[AW-1:0];
      w_q_next    = w_rd_acc ? r_mem[w_head_addr] : r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !srst) r_mem[r_wr_ptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_q           <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_mty         <= 1'b1;
      r_almost_mty  <= 1'b1;
    end else if (srst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_q           <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_mty         <= 1'b1;
      r_almost_mty  <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_q           <= w_q_next;
      r_full        <= (w_level_next == LW'(DEPTH));
      r_almost_full <= (w_level_next >= LW'(DEPTH - ALMOST_FULL));
      r_mty         <= (w_level_next == '0);
      r_almost_mty  <= (w_level_next <= LW'(ALMOST_MTY));
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (srst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr && !w_wr_acc) r_overflow  <= 1'b1;
      if (rd && r_mty)     r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign q           = r_q;
  assign level       = w_level;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign mty         = r_mty;
  assign almost_mty  = r_almost_mty;

endmodule

// File: tb/tb_fifo_ext.sv
// Bench for fifo_ext: a standard-read and an FWFT instance share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_fifo_ext;

  localparam int DW = 128;
  localparam int D  = 16;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit EF = 1'b1;
`else
  localparam bit EF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst, srst, wr, rd;
  logic [DW-1:0] data;

  logic [DW-1:0] q_s, q_f;
  logic [4:0]    lvl_s, lvl_f;
  logic          full_s, af_s, mty_s, am_s, ovf_s, unf_s;
  logic          full_f, af_f, mty_f, am_f, ovf_f, unf_f;

  fifo_ext #(.DATA_WIDTH(DW), .DEPTH(D), .ALMOST_MTY(1), .ALMOST_FULL(1), .FWFT(0)) u_std (
    .clk(clk), .arst(arst), .srst(srst), .wr(wr), .rd(rd), .data(data),
    .q(q_s), .level(lvl_s), .full(full_s), .almost_full(af_s), .mty(mty_s),
    .almost_mty(am_s), .overflow(ovf_s), .underflow(unf_s)
  );

  fifo_ext #(.DATA_WIDTH(DW), .DEPTH(D), .ALMOST_MTY(1), .ALMOST_FULL(1), .FWFT(1)) u_fwft (
    .clk(clk), .arst(arst), .srst(srst), .wr(wr), .rd(rd), .data(data),
    .q(q_f), .level(lvl_f), .full(full_f), .almost_full(af_f), .mty(mty_f),
    .almost_mty(am_f), .overflow(ovf_f), .underflow(unf_f)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_qs, m_qf;
  bit            m_ovf, m_unf;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string ph);
    int n;
    n = mq.size();
    chk({ph, ":level"},       DW'(lvl_s),  DW'(n));
    chk({ph, ":full"},        DW'(full_s), DW'(n == D));
    chk({ph, ":almost_full"}, DW'(af_s),   DW'(n >= D - 1));
    chk({ph, ":mty"},         DW'(mty_s),  DW'(n == 0));
    chk({ph, ":almost_mty"},  DW'(am_s),   DW'(n <= 1));
    chk({ph, ":overflow"},    DW'(ovf_s),  DW'(m_ovf));
    chk({ph, ":underflow"},   DW'(unf_s),  DW'(m_unf));
    chk({ph, ":q_std"},       q_s,         m_qs);
    chk({ph, ":level_fwft"},  DW'(lvl_f),  DW'(n));
    chk({ph, ":mty_fwft"},    DW'(mty_f),  DW'(n == 0));
    chk({ph, ":q_fwft"},      q_f,         m_qf);
    chk({ph, ":ovf_fwft"},    DW'(ovf_f),  DW'(m_ovf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_qs  = '0;
    m_qf  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit s,
                      input string ph);
    bit r_ok, w_ok;
    wr = w; rd = r; data = d; srst = s;
    @(posedge clk);
    if (s) begin
      model_reset();
    end else begin
      r_ok = r && (mq.size() > 0);
      w_ok = w && ((mq.size() < D) || r_ok);
      if (EF && w && !w_ok)         m_ovf = 1'b1;
      if (EF && r && mq.size() == 0) m_unf = 1'b1;
      if (r_ok) m_qs = mq.pop_front();
      if (w_ok) mq.push_back(d);
      if (mq.size() > 0) m_qf = mq[0];
    end
    #1;
    chk_all(ph);
  endtask

  initial begin
    arst = 1'b1; srst = 1'b0; wr = 1'b0; rd = 1'b0; data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    arst = 1'b0;

    // asynchronous reset mid-cycle with level 5
    for (int i = 0; i < 5; i++) step(1, 0, rnd128(), 0, "t1_fill");
    #2 arst = 1'b1;
    #1 model_reset();
    chk_all("t1_arst");
    arst = 1'b0;

    // fill 0..15, then an extra write is dropped
    for (int i = 0; i < D; i++) step(1, 0, DW'(i), 0, "t2_wr");
    step(1, 0, DW'('hAA), 0, "t2_ovf");

    // drain in order, then an extra read
    for (int i = 0; i < D; i++) step(0, 1, rnd128(), 0, "t3_rd");
    step(0, 1, rnd128(), 0, "t3_unf");

    // simultaneous wr&rd at full and at empty
    step(0, 0, '0, 1, "t4_clr");
    for (int i = 0; i < D; i++) step(1, 0, rnd128(), 0, "t4_fill");
    step(1, 1, rnd128(), 0, "t4_full_wrrd");
    for (int i = 0; i < D; i++) step(0, 1, rnd128(), 0, "t4_drain");
    step(1, 1, rnd128(), 0, "t4_empty_wrrd");
    for (int i = 0; i < 40; i++) step(1'($urandom), 1'($urandom), rnd128(), 0, "t4_mix");
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, rnd128(),
           $urandom_range(0, 49) == 0, "rand");

    // FWFT head presentation
    step(0, 0, '0, 1, "t5_clr");
    step(1, 0, DW'(5), 0, "t5_wr5");
    step(0, 0, rnd128(), 0, "t5_idle");
    step(1, 0, DW'(6), 0, "t5_wr6");
    step(0, 1, rnd128(), 0, "t5_rd");

    // srst beats a concurrent write and clears the sticky flag
    step(0, 0, '0, 1, "t6_clr");
    for (int i = 0; i < D; i++) step(1, 0, rnd128(), 0, "t6_fill");
    step(1, 0, rnd128(), 0, "t6_ovf");
    for (int i = 0; i < 9; i++) step(0, 1, rnd128(), 0, "t6_rd");
    step(1, 0, rnd128(), 1, "t6_srst");
    step(0, 0, rnd128(), 0, "t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
